// File: rtl/wm_timer_sensor.sv
`default_nettype none
// ============================================================================
// Module   : wm_timer_sensor
// Purpose  : Models the tank level and the wash/spin phase timers that feed
//            the controller's sensor inputs.
// Revision : 1.0 - initial release
// ============================================================================
module wm_timer_sensor #(
    parameter int PRESCALE    = 4,
    parameter int CYCLE_TICKS = 8,
    parameter int SPIN_TICKS  = 6,
    parameter int LEVEL_MAX   = 10,
    parameter int LEVEL_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               motor_on,
    input  logic               fill_value_on,
    input  logic               drain_value_on,
    input  logic               done,
    output logic               filled,
    output logic               drained,
    output logic               cycle_timeout,
    output logic               spin_timeout,
    output logic [LEVEL_W-1:0] level
);

    localparam int c_PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_MAX_TICKS = (CYCLE_TICKS > SPIN_TICKS) ? CYCLE_TICKS : SPIN_TICKS;
    localparam int c_CNT_W     = $clog2(c_MAX_TICKS + 1);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0] c_CYC_LAST  = c_CNT_W'(CYCLE_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_SPIN_LAST = c_CNT_W'(SPIN_TICKS - 1);
    localparam logic [LEVEL_W-1:0] c_LEVEL_MAX = LEVEL_W'(LEVEL_MAX);

    localparam logic [2:0] T_IDLE    = 3'd0;
    localparam logic [2:0] T_WASH    = 3'd1;
    localparam logic [2:0] T_WASH_TO = 3'd2;
    localparam logic [2:0] T_SPIN    = 3'd3;
    localparam logic [2:0] T_SPIN_TO = 3'd4;

    logic [c_PRE_W-1:0] r_pre_cnt;
    logic               w_tick;
    logic [LEVEL_W-1:0] r_level;
    logic               w_inc;
    logic               w_dec;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_ph_cnt;
    logic [c_CNT_W-1:0] w_ph_cnt_next;

    // Free-running timebase; phases never gate it, so tick alignment is set
    // only by reset.
    assign w_tick = (r_pre_cnt == c_PRE_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
        end
    end

    assign w_inc = w_tick & fill_value_on & ~drain_value_on & (r_level < c_LEVEL_MAX);
    assign w_dec = w_tick & drain_value_on & ~fill_value_on & (r_level != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= '0;
        end else if (w_inc) begin
            r_level <= r_level + LEVEL_W'(1);
        end else if (w_dec) begin
            r_level <= r_level - LEVEL_W'(1);
        end
    end

    assign level   = r_level;
    assign filled  = (r_level == c_LEVEL_MAX);
    assign drained = (r_level == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= T_IDLE;
            r_ph_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ph_cnt <= w_ph_cnt_next;
        end
    end

    // The counter is cleared whenever a phase is not actively timing, so any
    // new phase starts from zero.
    always_comb begin
        w_state_next  = r_state;
        w_ph_cnt_next = '0;
        case (r_state)
            T_IDLE: begin
                if (motor_on) begin
                    w_state_next = T_WASH;
                end else if (drain_value_on && drained) begin
                    w_state_next = T_SPIN;
                end
            end
            T_WASH: begin
                w_ph_cnt_next = r_ph_cnt;
                if (!motor_on) begin
                    w_state_next  = T_IDLE;
                    w_ph_cnt_next = '0;
                end else if (w_tick) begin
                    if (r_ph_cnt == c_CYC_LAST) begin
                        w_state_next  = T_WASH_TO;
                        w_ph_cnt_next = '0;
                    end else begin
                        w_ph_cnt_next = r_ph_cnt + c_CNT_W'(1);
                    end
                end
            end
            T_WASH_TO: begin
                if (!motor_on) begin
                    w_state_next = T_IDLE;
                end
            end
            T_SPIN: begin
                w_ph_cnt_next = r_ph_cnt;
                if (!drain_value_on || done) begin
                    w_state_next  = T_IDLE;
                    w_ph_cnt_next = '0;
                end else if (w_tick) begin
                    if (r_ph_cnt == c_SPIN_LAST) begin
                        w_state_next  = T_SPIN_TO;
                        w_ph_cnt_next = '0;
                    end else begin
                        w_ph_cnt_next = r_ph_cnt + c_CNT_W'(1);
                    end
                end
            end
            T_SPIN_TO: begin
                if (!drain_value_on || done) begin
                    w_state_next = T_IDLE;
                end
            end
            default: begin
                w_state_next = T_IDLE;
            end
        endcase
    end

    always_comb begin
        cycle_timeout = (r_state == T_WASH_TO);
        spin_timeout  = (r_state == T_SPIN_TO);
    end

endmodule
`default_nettype wire

// File: tb/tb_wm_timer_sensor.sv
`default_nettype none
// ============================================================================
// Module   : tb_wm_timer_sensor
// Purpose  : Directed vector table on a PRESCALE=1 instance plus hand-written
//            wash sequences on a PRESCALE=4 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wm_timer_sensor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motor_on = 1'b0;
    logic       fill_value_on = 1'b0;
    logic       drain_value_on = 1'b0;
    logic       done = 1'b0;

    logic       filled1, drained1, cto1, sto1;
    logic [3:0] level1;
    logic       filled4, drained4, cto4, sto4;
    logic [3:0] level4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wm_timer_sensor #(.PRESCALE(1), .CYCLE_TICKS(8), .SPIN_TICKS(6),
                      .LEVEL_MAX(10), .LEVEL_W(4)) dut_p1 (
        .clk(clk), .reset(reset), .motor_on(motor_on),
        .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
        .done(done), .filled(filled1), .drained(drained1),
        .cycle_timeout(cto1), .spin_timeout(sto1), .level(level1));

    wm_timer_sensor #(.PRESCALE(4), .CYCLE_TICKS(8), .SPIN_TICKS(6),
                      .LEVEL_MAX(10), .LEVEL_W(4)) dut_p4 (
        .clk(clk), .reset(reset), .motor_on(motor_on),
        .fill_value_on(fill_value_on), .drain_value_on(drain_value_on),
        .done(done), .filled(filled4), .drained(drained4),
        .cycle_timeout(cto4), .spin_timeout(sto4), .level(level4));

    typedef struct {
        logic       rst, mot, fil, drn, dn;
        logic [3:0] lvl;
        logic       fl, dr, cto, sto;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, mot, fil, drn, dn,
                       input int lvl, input logic fl, dr, cto, sto);
        vec_t v;
        v.rst = rst; v.mot = mot; v.fil = fil; v.drn = drn; v.dn = dn;
        v.lvl = 4'(lvl); v.fl = fl; v.dr = dr; v.cto = cto; v.sto = sto;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the PRESCALE=4 instance raises cycle_timeout; n counts edges
    // from the wash entry edge (n=1), so entry-to-timeout = n-1 clocks.
    task automatic wait_cto4(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!cto4 && n < 100);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;

        // Reset with every input high
        add(1,1,1,1,1, 0, 0,1,0,0);
        add(1,1,1,1,1, 0, 0,1,0,0);
        // Fill to the limit, then saturate
        for (int k = 1; k <= 10; k++) add(0,0,1,0,0, k, k == 10, 0,0,0);
        for (int k = 0; k < 5; k++)   add(0,0,1,0,0, 10, 1,0,0,0);
        // Both valves: hold, and no spin because the tank is not drained
        add(0,0,1,1,0, 10, 1,0,0,0);
        add(0,0,1,1,0, 10, 1,0,0,0);
        // Drain to empty
        for (int k = 1; k <= 10; k++) add(0,0,0,1,0, 10 - k, 0, k == 10, 0,0);
        // Spin entry on the next edge, timeout 6 clocks later
        for (int k = 0; k < 6; k++) add(0,0,0,1,0, 0, 0,1,0,0);
        add(0,0,0,1,0, 0, 0,1,0,1);
        add(0,0,0,1,0, 0, 0,1,0,1);
        // done releases spin_timeout after one clock
        add(0,0,0,1,1, 0, 0,1,0,0);
        add(0,0,0,0,0, 0, 0,1,0,0);
        // Draining with a non-empty tank never starts a spin
        for (int k = 1; k <= 5; k++) add(0,0,1,0,0, k, 0,0,0,0);
        add(0,0,1,1,0, 5, 0,0,0,0);
        add(0,0,0,1,0, 4, 0,0,0,0);
        add(0,0,0,1,0, 3, 0,0,0,0);
        // Wash timeout exactly 8 clocks after entry, released one clock after motor off
        add(0,1,0,0,0, 3, 0,0,0,0);
        for (int k = 0; k < 7; k++) add(0,1,0,0,0, 3, 0,0,0,0);
        add(0,1,0,0,0, 3, 0,0,1,0);
        add(0,1,0,0,0, 3, 0,0,1,0);
        add(0,0,0,0,0, 3, 0,0,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset          = vecs[i].rst;
            motor_on       = vecs[i].mot;
            fill_value_on  = vecs[i].fil;
            drain_value_on = vecs[i].drn;
            done           = vecs[i].dn;
            step();
            chk($sformatf("vec%0d level", i),   int'(level1),   int'(vecs[i].lvl));
            chk($sformatf("vec%0d filled", i),  int'(filled1),  int'(vecs[i].fl));
            chk($sformatf("vec%0d drained", i), int'(drained1), int'(vecs[i].dr));
            chk($sformatf("vec%0d cyc_to", i),  int'(cto1),     int'(vecs[i].cto));
            chk($sformatf("vec%0d spin_to", i), int'(sto1),     int'(vecs[i].sto));
        end

        motor_on = 0; fill_value_on = 0; drain_value_on = 0; done = 0;

        // PRESCALE=4 level: ticks on the 4th and 8th edge after reset
        do_reset();
        fill_value_on = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("p4 fill level", int'(level4), 2);
        fill_value_on = 1'b0;

        // Wash timeout: entry one edge after reset, 8th tick 31 clocks later
        do_reset();
        motor_on = 1'b1;
        wait_cto4(n);
        chk("p4 wash latency", n - 1, 31);
        chk("p4 wash latency window", int'((n - 1) >= 29 && (n - 1) <= 32), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("p4 wash hold", int'(cto4), 1);
            chk("p4 spin_to low", int'(sto4), 0);
        end
        motor_on = 1'b0;
        step();
        chk("p4 wash release", int'(cto4), 0);

        // Wash abort after 3 ticks, then restart from zero
        do_reset();
        motor_on = 1'b1;
        for (int k = 0; k < 12; k++) step();
        chk("p4 abort pre cto", int'(cto4), 0);
        motor_on = 1'b0;
        step();
        chk("p4 abort idle cto", int'(cto4), 0);
        motor_on = 1'b1;
        wait_cto4(n);
        chk("p4 abort restart latency", n - 1, 30);

        // Reset mid-wash at tick 5 discards progress
        do_reset();
        motor_on = 1'b1;
        for (int k = 0; k < 20; k++) step();
        reset = 1'b1;
        step();
        chk("p4 mid reset cto", int'(cto4), 0);
        chk("p4 mid reset level", int'(level4), 0);
        reset = 1'b0;
        wait_cto4(n);
        chk("p4 mid reset latency", n - 1, 31);
        motor_on = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
